// File: rtl/structure_scan_controller_pkg.sv
// Shared definitions for the structure scan controller: command codes used by
// the SPI command decoder, and the scan FSM state encoding.
package structure_scan_controller_pkg;

  // Command codes carried in cmd_word[15:12]
  localparam logic [3:0] CMD_SEL_START = 4'h0;
  localparam logic [3:0] CMD_SEL_END   = 4'h1;
  localparam logic [3:0] CMD_REPEATS   = 4'h2;
  localparam logic [3:0] CMD_FLAGS     = 4'h3;
  localparam logic [3:0] CMD_MODE      = 4'h4;
  localparam logic [3:0] CMD_PERIOD    = 4'h5;
  localparam logic [3:0] CMD_START     = 4'hA;
  localparam logic [3:0] CMD_ABORT     = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_FIRE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } scan_state_t;

  // A programmed repeat count of zero still gives one run per structure
  function automatic logic [11:0] eff_repeats(input logic [11:0] repeats);
    return (repeats == 12'd0) ? 12'd1 : repeats;
  endfunction

endpackage

// File: rtl/structure_scan_controller_trig_sync_edge.sv
// Two-flop synchroniser for the asynchronous trigger input followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module trig_sync_edge (
  input  logic clk,
  input  logic res_n,
  input  logic trig_in,
  output logic trig_pulse
);

  logic sync_meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchronise trig_in and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      prev_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= trig_in;
      sync_reg      <= sync_meta_reg;
      prev_reg      <= sync_reg;
    end
  end

  assign trig_pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/structure_scan_controller.sv
// Scan scheduler for the pixel test-structure sequencer: steps SEL over a
// programmed (possibly wrapping) range, firing N sequencer runs per structure,
// each run gated by a trigger (external edge or internal period) and by the
// sequencer ready handshake.
module structure_scan_controller
  import structure_scan_controller_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 15,
  parameter int PERIOD_SHIFT = 4
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_word,
  input  logic        trig_in,
  input  logic        seq_ready,
  output logic        seq_run,
  output logic [3:0]  seq_sel,
  output logic        seq_block_reset,
  output logic        seq_block_hold,
  output logic        seq_polarity,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] run_count
);

  localparam int         PCNT_W   = 12 + PERIOD_SHIFT;
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  // Configuration registers, writable only while idle
  logic [3:0]  sel_start_reg;
  logic [3:0]  sel_end_reg;
  logic [11:0] repeats_reg;
  logic [2:0]  flags_reg;
  logic        mode_reg;
  logic [11:0] period_reg;

  // Scan state
  scan_state_t       state_reg;
  logic [11:0]       rep_cnt_reg;
  logic [7:0]        ack_cnt_reg;
  logic [PCNT_W-1:0] period_cnt_reg;

  // Registered outputs
  logic        seq_run_reg;
  logic [3:0]  sel_reg;
  logic [2:0]  flags_out_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        error_reg;
  logic [15:0] run_count_reg;

  logic [3:0]        cmd_code;
  logic [11:0]       cmd_data;
  logic              cmd_start;
  logic              cmd_abort;
  logic              trig_pulse;
  logic              trig_event;
  logic [PCNT_W-1:0] period_reload;
  logic [11:0]       rep_last;

  assign cmd_code      = cmd_word[15:12];
  assign cmd_data      = cmd_word[11:0];
  assign cmd_start     = cmd_valid && (cmd_code == CMD_START);
  assign cmd_abort     = cmd_valid && (cmd_code == CMD_ABORT);
  assign period_reload = PCNT_W'(period_reg) << PERIOD_SHIFT;
  assign rep_last      = eff_repeats(repeats_reg) - 12'd1;

  // Internal mode fires when the period counter has run down; external mode
  // uses the synchronised trigger edge. Either is only honoured in ARM.
  assign trig_event = mode_reg ? (period_cnt_reg == '0) : trig_pulse;

  trig_sync_edge u_trig_sync_edge (
    .clk        (clk),
    .res_n      (res_n),
    .trig_in    (trig_in),
    .trig_pulse (trig_pulse)
  );

  // Configuration writes from the command decoder, accepted only when idle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sel_start_reg <= 4'd0;
      sel_end_reg   <= 4'd0;
      repeats_reg   <= 12'd1;
      flags_reg     <= 3'd0;
      mode_reg      <= 1'b0;
      period_reg    <= 12'd0;
    end else if (cmd_valid && (state_reg == ST_IDLE)) begin
      case (cmd_code)
        CMD_SEL_START: sel_start_reg <= cmd_data[3:0];
        CMD_SEL_END:   sel_end_reg   <= cmd_data[3:0];
        CMD_REPEATS:   repeats_reg   <= cmd_data;
        CMD_FLAGS:     flags_reg     <= cmd_data[2:0];
        CMD_MODE:      mode_reg      <= cmd_data[0];
        CMD_PERIOD:    period_reg    <= cmd_data;
        default:       ;
      endcase
    end
  end

  // Scan FSM with all sequencer-facing outputs registered
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg      <= ST_IDLE;
      rep_cnt_reg    <= 12'd0;
      ack_cnt_reg    <= 8'd0;
      period_cnt_reg <= '0;
      seq_run_reg    <= 1'b0;
      sel_reg        <= 4'd0;
      flags_out_reg  <= 3'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      run_count_reg  <= 16'd0;
    end else begin
      done_reg <= 1'b0;
      if (cmd_abort && (state_reg != ST_IDLE)) begin
        // SEL and flags keep their values; only the run and busy are dropped
        state_reg   <= ST_IDLE;
        seq_run_reg <= 1'b0;
        busy_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cmd_start) begin
              state_reg     <= ST_LOAD;
              sel_reg       <= sel_start_reg;
              flags_out_reg <= flags_reg;
              rep_cnt_reg   <= 12'd0;
              run_count_reg <= 16'd0;
              error_reg     <= 1'b0;
              busy_reg      <= 1'b1;
            end
          end
          ST_LOAD: begin
            period_cnt_reg <= period_reload;
            state_reg      <= ST_ARM;
          end
          ST_ARM: begin
            if (trig_event) begin
              if (seq_ready) begin
                state_reg   <= ST_FIRE;
                seq_run_reg <= 1'b1;
                ack_cnt_reg <= 8'd0;
                if (run_count_reg != 16'hFFFF) begin
                  run_count_reg <= run_count_reg + 16'd1;
                end
              end else if (mode_reg) begin
                // Trigger dropped because the sequencer was busy; start a new period
                period_cnt_reg <= period_reload;
              end
            end else if (mode_reg) begin
              period_cnt_reg <= period_cnt_reg - 1'b1;
            end
          end
          ST_FIRE: begin
            if (!seq_ready) begin
              seq_run_reg <= 1'b0;
              state_reg   <= ST_WAIT;
            end else if (ack_cnt_reg == ACK_LAST) begin
              error_reg   <= 1'b1;
              seq_run_reg <= 1'b0;
              state_reg   <= ST_WAIT;
            end else begin
              ack_cnt_reg <= ack_cnt_reg + 8'd1;
            end
          end
          ST_WAIT: begin
            if (seq_ready) begin
              state_reg <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (rep_cnt_reg == rep_last) begin
              rep_cnt_reg <= 12'd0;
              if (sel_reg == sel_end_reg) begin
                state_reg <= ST_DONE;
              end else begin
                sel_reg        <= sel_reg + 4'd1;
                period_cnt_reg <= period_reload;
                state_reg      <= ST_ARM;
              end
            end else begin
              rep_cnt_reg    <= rep_cnt_reg + 12'd1;
              period_cnt_reg <= period_reload;
              state_reg      <= ST_ARM;
            end
          end
          ST_DONE: begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign seq_run         = seq_run_reg;
  assign seq_sel         = sel_reg;
  assign seq_block_reset = flags_out_reg[0];
  assign seq_block_hold  = flags_out_reg[1];
  assign seq_polarity    = flags_out_reg[2];
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign error           = error_reg;
  assign run_count       = run_count_reg;

endmodule

// File: tb/tb_structure_scan_controller.sv
// Scoreboard bench for structure_scan_controller: expected SEL values are
// queued as scans are programmed and popped on every seq_run rising edge.
module tb_structure_scan_controller;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_word = 16'd0;
  logic        trig_in = 1'b0;
  logic        seq_ready = 1'b1;
  logic        seq_run;
  logic [3:0]  seq_sel;
  logic        seq_block_reset;
  logic        seq_block_hold;
  logic        seq_polarity;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] run_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] sb[$];
  int rise_cnt = 0;
  int done_cnt = 0;
  int cur_len = 0;
  int last_len = 0;
  logic prev_run = 1'b0;

  // Sequencer model controls
  logic model_stuck = 1'b0;
  logic model_hold_low = 1'b0;
  int   low_cnt = 0;

  structure_scan_controller #(.ACK_TIMEOUT(15), .PERIOD_SHIFT(4)) dut (
    .clk             (clk),
    .res_n           (res_n),
    .cmd_valid       (cmd_valid),
    .cmd_word        (cmd_word),
    .trig_in         (trig_in),
    .seq_ready       (seq_ready),
    .seq_run         (seq_run),
    .seq_sel         (seq_sel),
    .seq_block_reset (seq_block_reset),
    .seq_block_hold  (seq_block_hold),
    .seq_polarity    (seq_polarity),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .run_count       (run_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Sequencer model: drops ready for 5 cycles after seeing seq_run
  initial begin
    forever begin
      @(negedge clk);
      if (model_hold_low) begin
        seq_ready = 1'b0;
      end else if (model_stuck) begin
        seq_ready = 1'b1;
      end else if (seq_ready && seq_run) begin
        seq_ready = 1'b0;
        low_cnt = 5;
      end else if (!seq_ready) begin
        if (low_cnt <= 1) seq_ready = 1'b1;
        else low_cnt--;
      end
    end
  end

  // Output monitor: scoreboard compare on run start, run length, done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (seq_run && !prev_run) begin
        rise_cnt++;
        if (sb.size() == 0) check("sb_unexpected_run", 32'(seq_sel), 32'hFFFF_FFFF);
        else check("run_sel", 32'(seq_sel), 32'(sb.pop_front()));
      end
      if (seq_run) cur_len++;
      else if (prev_run) begin
        last_len = cur_len;
        cur_len = 0;
      end
      if (done) done_cnt++;
      prev_run = seq_run;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] code, input logic [11:0] data);
    cmd_word = {code, data};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] s, input logic [3:0] e, input logic [11:0] reps,
                     input logic m, input logic [11:0] per);
    send_cmd(4'h0, {8'd0, s});
    send_cmd(4'h1, {8'd0, e});
    send_cmd(4'h2, reps);
    send_cmd(4'h4, {11'd0, m});
    send_cmd(4'h5, per);
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    repeat (4) tick();
    trig_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_runs(input int n, input int budget);
    int k = 0;
    while (rise_cnt < n && k < budget) begin
      tick();
      k++;
    end
    if (rise_cnt < n) check("run_timeout", 32'(rise_cnt), 32'(n));
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check("done_pulses", 32'(done_cnt), 32'(n));
  endtask

  initial begin
    int d0;
    int r0;
    int k;

    // Reset state
    repeat (3) tick();
    check("rst_seq_run", 32'(seq_run), 0);
    check("rst_sel", 32'(seq_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_run_count", 32'(run_count), 0);
    res_n = 1'b1;
    repeat (2) tick();

    // 1: internal period, 2 repeats over SEL 2..4
    cfg(4'd2, 4'd4, 12'd2, 1'b1, 12'd1);
    sb.push_back(4'd2); sb.push_back(4'd2); sb.push_back(4'd3);
    sb.push_back(4'd3); sb.push_back(4'd4); sb.push_back(4'd4);
    d0 = done_cnt;
    send_cmd(4'hA, 12'd0);
    check("t1_busy", 32'(busy), 1);
    wait_done(d0 + 1, 3000);
    repeat (5) tick();
    check("t1_run_count", 32'(run_count), 6);
    check("t1_single_done", 32'(done_cnt), 32'(d0 + 1));
    check("t1_busy_end", 32'(busy), 0);
    check("t1_error", 32'(error), 0);

    // 2: external trigger, wrapping range 14..1, repeats 0 treated as 1
    cfg(4'd14, 4'd1, 12'd0, 1'b0, 12'd0);
    sb.push_back(4'd14); sb.push_back(4'd15); sb.push_back(4'd0); sb.push_back(4'd1);
    d0 = done_cnt;
    r0 = rise_cnt;
    send_cmd(4'hA, 12'd0);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      pulse_trig();
      wait_runs(r0 + i + 1, 200);
      repeat (15) tick();
      if (i < 3) check("t2_busy_mid", 32'(busy), 1);
    end
    wait_done(d0 + 1, 100);
    check("t2_busy_end", 32'(busy), 0);
    check("t2_run_count", 32'(run_count), 4);

    // 3: ready stuck high -> ack timeout after 15 cycles, scan still completes
    model_stuck = 1'b1;
    cfg(4'd5, 4'd5, 12'd1, 1'b1, 12'd0);
    sb.push_back(4'd5);
    d0 = done_cnt;
    send_cmd(4'hA, 12'd0);
    wait_done(d0 + 1, 300);
    check("t3_run_len", 32'(last_len), 15);
    check("t3_error", 32'(error), 1);
    check("t3_run_count", 32'(run_count), 1);
    check("t3_busy", 32'(busy), 0);

    // 4: ABORT during FIRE, config write ignored while busy
    cfg(4'd3, 4'd7, 12'd1, 1'b1, 12'd0);
    sb.push_back(4'd3);
    d0 = done_cnt;
    r0 = rise_cnt;
    send_cmd(4'hA, 12'd0);
    wait_runs(r0 + 1, 100);
    repeat (3) tick();
    check("t4_error_cleared", 32'(error), 0);
    send_cmd(4'hB, 12'd0);
    check("t4_run_after_abort", 32'(seq_run), 0);
    check("t4_busy_after_abort", 32'(busy), 0);
    repeat (20) tick();
    check("t4_no_done", 32'(done_cnt), 32'(d0));
    check("t4_sel_hold", 32'(seq_sel), 3);
    model_stuck = 1'b0;
    cfg(4'd3, 4'd3, 12'd1, 1'b1, 12'd4);
    send_cmd(4'hA, 12'd0);
    send_cmd(4'h0, 12'd9);
    send_cmd(4'hB, 12'd0);
    sb.push_back(4'd3);
    d0 = done_cnt;
    send_cmd(4'hA, 12'd0);
    wait_done(d0 + 1, 500);

    // 5: trigger edges in IDLE and while sequencer not ready are dropped
    cfg(4'd6, 4'd6, 12'd1, 1'b0, 12'd0);
    r0 = rise_cnt;
    pulse_trig();
    repeat (10) tick();
    check("t5_idle_no_run", 32'(rise_cnt), 32'(r0));
    check("t5_idle_run_count", 32'(run_count), 1);
    model_hold_low = 1'b1;
    repeat (2) tick();
    sb.push_back(4'd6);
    d0 = done_cnt;
    send_cmd(4'hA, 12'd0);
    repeat (5) tick();
    pulse_trig();
    repeat (10) tick();
    check("t5_notready_no_run", 32'(rise_cnt), 32'(r0));
    check("t5_notready_run_count", 32'(run_count), 0);
    model_hold_low = 1'b0;
    repeat (3) tick();
    pulse_trig();
    wait_done(d0 + 1, 200);
    check("t5_run_count", 32'(run_count), 1);

    // 6: asynchronous reset in WAIT, then START with reset configuration
    cfg(4'd9, 4'd9, 12'd3, 1'b1, 12'd0);
    send_cmd(4'h3, 12'd7);
    sb.push_back(4'd9); sb.push_back(4'd9); sb.push_back(4'd9);
    r0 = rise_cnt;
    send_cmd(4'hA, 12'd0);
    wait_runs(r0 + 1, 100);
    k = 0;
    while (seq_run && k < 50) begin
      tick();
      k++;
    end
    check("t6_in_wait", 32'(seq_run), 0);
    check("t6_flags_before", 32'({seq_polarity, seq_block_hold, seq_block_reset}), 7);
    #2;
    res_n = 1'b0;
    #1;
    check("t6_rst_seq_run", 32'(seq_run), 0);
    check("t6_rst_sel", 32'(seq_sel), 0);
    check("t6_rst_flags", 32'({seq_polarity, seq_block_hold, seq_block_reset}), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_run_count", 32'(run_count), 0);
    sb.delete();
    repeat (3) tick();
    res_n = 1'b1;
    repeat (8) tick();
    sb.push_back(4'd0);
    d0 = done_cnt;
    send_cmd(4'hA, 12'd0);
    repeat (5) tick();
    pulse_trig();
    wait_done(d0 + 1, 200);
    check("t6_run_count", 32'(run_count), 1);
    check("t6_sel", 32'(seq_sel), 0);
    check("t6_flags", 32'({seq_polarity, seq_block_hold, seq_block_reset}), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
